seq_light_monitor: RTL

Checker and decoder for the five-lamp sequential lighting bus (a..e). It samples the lamp outputs of the lighting chaser, recovers the current step index, and measures how long each pattern is held. It also checks the step order and one-hot legality, and flags stalled sequences. It sits beside the chaser in the same clock domain, feeding status LEDs and the bring-up debug logic.

---
 rtl/seq_light_pkg.sv | 26 ++
 rtl/seq_light_decode.sv | 28 ++
 rtl/seq_light_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_light_pkg.sv
// Shared types and helpers for the sequential lighting bus monitor.
// Step encoding: 0 = blank, 1..5 = lamp a..e, 7 = more than one lamp lit.
package seq_light_pkg;

    typedef enum logic [1:0] {
        SYNC,
        LOCKED,
        FAULT
    } mon_state_t;

    localparam logic [2:0] STEP_BLANK   = 3'd0;
    localparam logic [2:0] STEP_ILLEGAL = 3'd7;
    localparam logic [2:0] LAST_STEP    = 3'd5;

    // The chaser wraps from the last lamp back to blank; unused codes also map to blank.
    function automatic logic [2:0] next_step(input logic [2:0] s);
        logic [2:0] n;
        if (s >= LAST_STEP) begin
            n = STEP_BLANK;
        end else begin
            n = s + 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_light_decode.sv
// One-hot lamp pattern to step index decoder.
// lamp[4] is lamp a (step 1) down to lamp[0], which is lamp e (step 5).
module seq_light_decode
    import seq_light_pkg::*;
(
    input  logic [4:0] lamp,
    output logic [2:0] step,
    output logic       is_illegal
);

    always_comb begin
        step       = STEP_BLANK;
        is_illegal = 1'b0;
        case (lamp)
            5'b00000: step = STEP_BLANK;
            5'b10000: step = 3'd1;
            5'b01000: step = 3'd2;
            5'b00100: step = 3'd3;
            5'b00010: step = 3'd4;
            5'b00001: step = 3'd5;
            default: begin
                step       = STEP_ILLEGAL;
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seq_light_monitor.sv
// Samples the five-lamp chaser bus, reports step and dwell on every pattern change,
// and tracks sequence order, one-hot legality and stalls with a SYNC/LOCKED/FAULT FSM.
module seq_light_monitor
    import seq_light_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 2000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    output logic [2:0]       step,
    output logic             step_valid,
    output logic [CNT_W-1:0] dwell,
    output logic             locked,
    output logic             order_err,
    output logic             multi_err,
    output logic             stall,
    output logic [7:0]       err_count
);

    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [4:0]       lamp_q;
    logic [4:0]       lamp_prev;
    logic [CNT_W-1:0] dwell_cnt;
    mon_state_t       state;

    logic       change;
    logic [2:0] decoded;
    logic       is_illegal;
    logic       multi_hit;
    logic       order_hit;
    logic       stall_hit;
    logic       err_event;

    seq_light_decode u_decode (
        .lamp       (lamp_q),
        .step       (decoded),
        .is_illegal (is_illegal)
    );

    // Stage 0: capture the lamp bus and the previous sample for change detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            lamp_q    <= 5'd0;
            lamp_prev <= 5'd0;
        end else begin
            lamp_q    <= {a, b, c, d, e};
            lamp_prev <= lamp_q;
        end
    end

    assign change = (lamp_q != lamp_prev);

    // step always mirrors the decode of lamp_prev, so it is the predecessor for order checks.
    assign multi_hit = change && is_illegal;
    assign order_hit = (state == LOCKED) && change && !is_illegal && (decoded != next_step(step));
    assign stall_hit = (state == LOCKED) && !change && (dwell_cnt == STALL_CNT);
    assign err_event = multi_hit || order_hit || stall_hit;

    // Stage 1: dwell counting and step reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_cnt  <= '0;
            step       <= STEP_BLANK;
            dwell      <= '0;
            step_valid <= 1'b0;
        end else begin
            step_valid <= change;
            if (change) begin
                dwell_cnt <= CNT_W'(1);
                step      <= decoded;
                dwell     <= dwell_cnt;
            end else if (dwell_cnt != CNT_MAX) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC;
            locked    <= 1'b0;
            order_err <= 1'b0;
            multi_err <= 1'b0;
            stall     <= 1'b0;
            err_count <= 8'd0;
        end else begin
            order_err <= 1'b0;
            multi_err <= 1'b0;
            stall     <= 1'b0;
            if (err_event && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            case (state)
                SYNC: begin
                    if (change && (step == STEP_BLANK) && (decoded == 3'd1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else if (multi_hit) begin
                        multi_err <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (multi_hit) begin
                        multi_err <= 1'b1;
                        state     <= FAULT;
                        locked    <= 1'b0;
                    end else if (order_hit) begin
                        order_err <= 1'b1;
                        state     <= FAULT;
                        locked    <= 1'b0;
                    end else if (stall_hit) begin
                        stall  <= 1'b1;
                        state  <= FAULT;
                        locked <= 1'b0;
                    end
                end
                FAULT: begin
                    if (change && (decoded == STEP_BLANK)) begin
                        state <= SYNC;
                    end else if (multi_hit) begin
                        multi_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SYNC;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
